timer_dev: RTL and testbench

- Programmable 32-bit down-counting timer peripheral, mapped through the system bridge.
- Its `irq` output drives one hardware-interrupt line into the coprocessor-0 cause IP field (`hwint[2]`). It is therefore the block directly upstream of cp0's interrupt request logic.
- Supports one-shot mode with a level-held interrupt and auto-reload mode with a single-cycle pulse.

---
 rtl/timer_dev_if.sv | 11 +
 rtl/timer_dev.sv | 128 ++++++++++++
 tb/tb_timer_dev.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_if.sv
// Register bus between the system bridge and timer_dev, plus the irq line to cp0.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_dev.sv
// 32-bit down-counting timer: one-shot (level irq) or auto-reload (pulse irq).
// Optional tick prescaler at addr 3 is compiled in with TIMER_PRESCALE_EN.
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t             r_state;
  logic               r_en;
  logic [1:0]         r_mode;
  logic               r_im;
  logic [CNT_W-1:0]   r_preset;
  logic [CNT_W-1:0]   r_count;
  logic               r_irq_flag;

  logic               w_auto;
  logic               w_tick;
  logic [31:0]        w_ps_rd;
  logic [31:0]        w_dout;

`ifdef TIMER_PRESCALE_EN
  logic [15:0]        r_pscale;
  logic [15:0]        r_pcnt;

  assign w_tick  = (r_pcnt == r_pscale);
  assign w_ps_rd = {16'd0, r_pscale};
`else
  assign w_tick  = 1'b1;
  assign w_ps_rd = 32'd0;
`endif

  // MODE 10/11 fall back to one-shot
  assign w_auto = (r_mode == 2'b01);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b0;
      r_mode     <= 2'b00;
      r_im       <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      r_pscale   <= '0;
      r_pcnt     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (r_en) r_state <= S_LOAD;
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
`ifdef TIMER_PRESCALE_EN
          r_pcnt  <= '0;
`endif
        end
        S_CNT: begin
          if (!r_en) begin
            r_state <= S_IDLE;
          end else begin
`ifdef TIMER_PRESCALE_EN
            r_pcnt <= w_tick ? 16'd0 : r_pcnt + 16'd1;
`endif
            if (w_tick) begin
              if (r_count == '0) begin
                r_state <= S_INT;
                if (!w_auto) r_irq_flag <= 1'b1;
              end else begin
                r_count <= r_count - ONE;
              end
            end
          end
        end
        S_INT: begin
          if (w_auto) begin
            r_state <= S_LOAD;
          end else begin
            r_en    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // CPU writes come last so they override same-edge FSM updates to EN and the flag
      if (bus.we) begin
        case (bus.addr)
          2'd0: begin
            r_en       <= bus.din[0];
            r_mode     <= bus.din[2:1];
            r_im       <= bus.din[3];
            r_irq_flag <= 1'b0;
          end
          2'd1: begin
            r_preset   <= bus.din[CNT_W-1:0];
            r_irq_flag <= 1'b0;
          end
`ifdef TIMER_PRESCALE_EN
          2'd3: r_pscale <= bus.din[15:0];
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_dout = 32'd0;
    case (bus.addr)
      2'd0:    w_dout = {28'd0, r_im, r_mode, r_en};
      2'd1:    w_dout = 32'(r_preset);
      2'd2:    w_dout = 32'(r_count);
      default: w_dout = w_ps_rd;
    endcase
  end

  assign bus.dout = w_dout;
  assign bus.irq  = r_im & (w_auto ? (r_state == S_INT) : r_irq_flag);

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: register table, directed timing sequences, randomized runs
// checked against closed-form expiry times derived from PRESET/PRESCALE.
module tb_timer_dev;

`ifdef TIMER_PRESCALE_EN
  localparam int PS_ON = 1;
`else
  localparam int PS_ON = 0;
`endif

  logic clk;
  logic rst;
  timer_dev_if bus();

  timer_dev #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // One clock edge with the given bus request; returns 1ns after the edge.
  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
    bus.we = w; bus.addr = a; bus.din = d;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a; #1;
    v = bus.dout;
  endtask

  task automatic stop();
    cyc(1'b1, 2'd0, 32'd0);
    repeat (4) idle();
  endtask

  // Expiry edge after the enabling CTRL write: LOAD + (N+1) ticks of (P+1) cycles, plus IDLE->LOAD.
  function automatic int expiry(input int n, input int p);
    return 2 + (n + 1) * (p + 1);
  endfunction

  logic [31:0] v;
  int          rn, rp, rpe, rt;
  logic [1:0]  rmode;
  logic        rim;
  logic        exp_irq;

  initial begin
    bus.we = 1'b0; bus.addr = 2'd0; bus.din = 32'd0;

    // reset held with a write pending: reset must win
    rst = 1'b0; bus.we = 1'b1; bus.din = 32'hFFFF_FFFF;
    @(posedge clk); #1; bus.addr = 2'd1;
    @(posedge clk); #1;
    rst = 1'b1; bus.we = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk("reset_read", v, 32'd0);
    end
    chk("reset_irq", 32'(bus.irq), 32'd0);

    // register write/readback table (EN kept 0 so the FSM stays idle)
    tbl[0] = '{2'd1, 32'h0000_0005, 32'h0000_0005};
    tbl[1] = '{2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[2] = '{2'd0, 32'hFFFF_FFF6, 32'h0000_0006};
    tbl[3] = '{2'd0, 32'h0000_0008, 32'h0000_0008};
    tbl[4] = '{2'd2, 32'h1234_5678, 32'h0000_0000};
    tbl[5] = '{2'd3, 32'hABCD_0007, (PS_ON != 0) ? 32'h0000_0007 : 32'h0};
    tbl[6] = '{2'd3, 32'h0000_0000, 32'h0000_0000};
    tbl[7] = '{2'd1, 32'h0000_0000, 32'h0000_0000};
    tbl[8] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, tbl[i].addr, tbl[i].din);
      rd(tbl[i].addr, v);
      chk($sformatf("regtbl[%0d]", i), v, tbl[i].exp);
    end

    // one-shot N=5: level irq from E8, EN self-clears
    cyc(1'b1, 2'd1, 32'd5);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 12; k++) begin
      idle();
      chk($sformatf("oneshot_irq@E%0d", k), 32'(bus.irq), 32'(k >= 8));
    end
    rd(2'd0, v);
    chk("oneshot_ctrl", v, 32'h8);
    cyc(1'b1, 2'd0, 32'd0);
    chk("oneshot_clear", 32'(bus.irq), 32'd0);
    repeat (3) idle();

    // auto-reload N=5: pulses every 8 cycles; EN cleared at E28 freezes COUNT
    cyc(1'b1, 2'd1, 32'd5);
    cyc(1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 28; k++) begin
      if (k == 28) cyc(1'b1, 2'd0, 32'hA);
      else idle();
      chk($sformatf("auto_irq@E%0d", k), 32'(bus.irq), 32'((k % 8) == 0));
    end
    for (int k = 29; k <= 36; k++) begin
      idle();
      chk("auto_stop_irq", 32'(bus.irq), 32'd0);
      rd(2'd2, v);
      chk("auto_frozen_count", v, 32'd3);
    end
    // re-enable restarts from LOAD with the new PRESET
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 10; k++) begin
      idle();
      chk($sformatf("restart_irq@E%0d", k), 32'(bus.irq), 32'((k % 5) == 0));
    end
    stop();

    // masked one-shot: FSM still expires (EN clears), irq stays low
    cyc(1'b1, 2'd1, 32'd3);
    cyc(1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      idle();
      chk("mask_irq", 32'(bus.irq), 32'd0);
    end
    rd(2'd0, v);
    chk("mask_ctrl_en_cleared", v, 32'h0);
    cyc(1'b1, 2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("mask_unmask_irq", 32'(bus.irq), 32'd0);
    end
    stop();

    // PRESET=0 expires after E3
    cyc(1'b1, 2'd1, 32'd0);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      idle();
      chk($sformatf("preset0_irq@E%0d", k), 32'(bus.irq), 32'(k >= 3));
    end
    stop();

    // PRESET rewritten mid-count: current expiry at E8, next period uses 100
    cyc(1'b1, 2'd1, 32'd5);
    cyc(1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 112; k++) begin
      if (k == 4) cyc(1'b1, 2'd1, 32'd100);
      else idle();
      chk($sformatf("rewrite_irq@E%0d", k), 32'(bus.irq), 32'(k == 8 || k == 111));
    end
    stop();

    // CPU CTRL write on the edge the FSM clears EN: write wins, timer restarts
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) cyc(1'b1, 2'd0, 32'h9);
      else idle();
      chk($sformatf("race_irq@E%0d", k), 32'(bus.irq), 32'(k == 5 || k >= 11));
      if (k == 6) begin
        rd(2'd0, v);
        chk("race_ctrl", v, 32'h9);
      end
    end
    stop();

    // synchronous reset mid-count
    cyc(1'b1, 2'd1, 32'd10);
    cyc(1'b1, 2'd0, 32'h9);
    repeat (5) idle();
    rst = 1'b0;
    idle();
    rst = 1'b1;
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      chk("midrst_read", v, 32'd0);
    end
    for (int k = 0; k < 15; k++) begin
      idle();
      chk("midrst_irq", 32'(bus.irq), 32'd0);
    end

    // prescaler: PRESCALE=2, PRESET=3 -> E14 with the feature, E6 without
    rt = expiry(3, (PS_ON != 0) ? 2 : 0);
    cyc(1'b1, 2'd3, 32'd2);
    cyc(1'b1, 2'd1, 32'd3);
    cyc(1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 16; k++) begin
      idle();
      chk($sformatf("prescale_irq@E%0d", k), 32'(bus.irq), 32'(k >= rt));
    end
    stop();

    // randomized runs against the closed-form expiry model
    for (int it = 0; it < 24; it++) begin
      rn    = $urandom_range(0, 12);
      rp    = $urandom_range(0, 3);
      rmode = 2'($urandom_range(0, 3));
      rim   = 1'($urandom_range(0, 1));
      rpe   = (PS_ON != 0) ? rp : 0;
      rt    = expiry(rn, rpe);
      cyc(1'b1, 2'd3, 32'(rp));
      cyc(1'b1, 2'd1, 32'(rn));
      cyc(1'b1, 2'd0, {28'd0, rim, rmode, 1'b1});
      for (int k = 1; k <= 2 * rt + 2; k++) begin
        idle();
        if (rmode == 2'b01) exp_irq = rim && ((k % rt) == 0);
        else                exp_irq = rim && (k >= rt);
        chk($sformatf("rand%0d_n%0d_p%0d_m%0d@E%0d", it, rn, rpe, rmode, k),
            32'(bus.irq), 32'(exp_irq));
      end
      stop();
    end
    cyc(1'b1, 2'd3, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
